scan_controller: RTL

SCAN_CONTROLLER -- requirements
Module: scan_controller

---
 rtl/scan_ctrl_pkg.sv | 18 +
 rtl/scan_byte_serdes.sv | 67 ++++++
 rtl/scan_controller.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan chain controller.
// Optional feature macro: SCAN_CTRL_READBACK_EN (adds the EMIT state and capture path).
package scan_ctrl_pkg;

    localparam int BYTE_BITS = 8;
    localparam int BIT_CNT_W = $clog2(BYTE_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
`ifdef SCAN_CTRL_READBACK_EN
        EMIT   = 3'd3,
`endif
        FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/scan_byte_serdes.sv
// Byte serialiser/deserialiser: holds the outgoing byte, the optional captured
// byte and the bit position within the current byte.
// Optional feature macro: SCAN_CTRL_READBACK_EN (adds the rx capture register).
module scan_byte_serdes
    import scan_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [BYTE_BITS-1:0] load_data,
    input  logic                 shift,
`ifdef SCAN_CTRL_READBACK_EN
    input  logic                 scan_out,
    output logic [BYTE_BITS-1:0] rx_data,
`endif
    output logic                 scan_in,
    output logic                 last_bit
);

    logic [BYTE_BITS-1:0] tx_reg, tx_next;
    logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;

    // Next tx byte and bit position; the counter wraps to 0 after the last bit.
    always_comb begin
        tx_next      = load ? load_data : tx_reg;
        bit_cnt_next = bit_cnt_reg;
        if (load)
            bit_cnt_next = '0;
        else if (shift)
            bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
    end

    // Register tx byte and bit position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_reg      <= '0;
            bit_cnt_reg <= '0;
        end else begin
            tx_reg      <= tx_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    // Bit k of the byte goes out on shift cycle k, LSB first; quiet when not shifting.
    assign scan_in  = shift & tx_reg[bit_cnt_reg];
    assign last_bit = shift && (bit_cnt_reg == BIT_CNT_W'(BYTE_BITS - 1));

`ifdef SCAN_CTRL_READBACK_EN
    logic [BYTE_BITS-1:0] rx_reg, rx_next;

    // Each rx bit captures scan_out on the shift edge of its own bit position.
    for (genvar gi = 0; gi < BYTE_BITS; gi++) begin : g_rx_bit
        assign rx_next[gi] = (shift && (bit_cnt_reg == BIT_CNT_W'(gi))) ? scan_out : rx_reg[gi];
    end

    // Register captured byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rx_reg <= '0;
        else
            rx_reg <= rx_next;
    end

    assign rx_data = rx_reg;
`endif

endmodule

// File: rtl/scan_controller.sv
// Full-chain scan exchange controller: shifts host bytes into a scan chain,
// one byte per 8 scan_enable cycles, optionally returning the displaced bits.
// Optional feature macro: SCAN_CTRL_READBACK_EN (readback via out_* handshake).
module scan_controller
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN  = 256,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  scan_enable,
    output logic                  scan_in,
    input  logic                  scan_out,
    output logic                  busy,
    output logic                  done
);

    localparam int NUM_BYTES = CHAIN_LEN / BYTE_BITS;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
    logic             load_tx;
    logic             last_bit;
    logic             last_byte;
    logic             cnt_clr;
    logic             cnt_adv;

    assign last_byte = (byte_cnt_reg == LAST_IDX);

    // State and byte counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
        end
    end

    // Next-state and output decode; scan_enable only ever asserted in SHIFT.
    always_comb begin
        state_next  = state_reg;
        in_ready    = 1'b0;
        scan_enable = 1'b0;
        done        = 1'b0;
        load_tx     = 1'b0;
        cnt_clr     = 1'b0;
        cnt_adv     = 1'b0;
`ifdef SCAN_CTRL_READBACK_EN
        out_valid   = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    cnt_clr    = 1'b1;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_tx    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                scan_enable = 1'b1;
                if (last_bit) begin
`ifdef SCAN_CTRL_READBACK_EN
                    state_next = EMIT;
`else
                    if (last_byte) begin
                        state_next = FINISH;
                    end else begin
                        state_next = LOAD;
                        cnt_adv    = 1'b1;
                    end
`endif
                end
            end
`ifdef SCAN_CTRL_READBACK_EN
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_byte) begin
                        state_next = FINISH;
                    end else begin
                        state_next = LOAD;
                        cnt_adv    = 1'b1;
                    end
                end
            end
`endif
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte index: cleared on start, advanced between bytes, never wraps.
    always_comb begin
        byte_cnt_next = byte_cnt_reg;
        if (cnt_clr)
            byte_cnt_next = '0;
        else if (cnt_adv)
            byte_cnt_next = byte_cnt_reg + CNT_W'(1);
    end

    assign busy = (state_reg != IDLE);

`ifdef SCAN_CTRL_READBACK_EN
    logic [BYTE_BITS-1:0] rx_data;

    scan_byte_serdes u_serdes (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_tx),
        .load_data (in_data),
        .shift     (scan_enable),
        .scan_out  (scan_out),
        .rx_data   (rx_data),
        .scan_in   (scan_in),
        .last_bit  (last_bit)
    );

    assign out_data = rx_data;
`else
    logic unused_inputs;

    scan_byte_serdes u_serdes (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_tx),
        .load_data (in_data),
        .shift     (scan_enable),
        .scan_in   (scan_in),
        .last_bit  (last_bit)
    );

    // Load-only build: no return path.
    assign out_valid     = 1'b0;
    assign out_data      = '0;
    assign unused_inputs = scan_out ^ out_ready;
`endif

endmodule
